// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and the
// default size of the attached byte-wide data memory.
package lsu_pkg;

  localparam int MEM_BYTES_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    FIN  = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } lsu_state_t;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns one 16-bit pipeline access into two
// little-endian byte accesses on a byte-wide data memory port.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  // Highest address whose high byte (addr+1) still lies inside the memory.
  localparam logic [15:0] LAST_OK = 16'(MEM_BYTES - 2);

  lsu_state_t  state;
  lsu_state_t  nextstate;
  logic        handshake;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [7:0]  lobyte;
  logic [7:0]  hibyte;

  assign handshake = req_valid && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextstate;
    end
  end

  always_comb begin
    nextstate = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          nextstate = (req_addr > LAST_OK) ? ERR : LO;
        end
      end
      LO:      nextstate = HI;
      HI:      nextstate = write ? RESP : FIN;
      FIN:     nextstate = RESP;
      RESP:    nextstate = IDLE;
      ERR:     nextstate = IDLE;
      default: nextstate = IDLE;
    endcase
  end

  // Read bytes arrive one cycle after their strobe, so the low byte is
  // taken while in HI and the high byte while in FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write  <= 1'b0;
      addr   <= 16'h0000;
      wdata  <= 16'h0000;
      lobyte <= 8'h00;
      hibyte <= 8'h00;
    end else begin
      if (handshake) begin
        write  <= req_write;
        addr   <= req_addr;
        wdata  <= req_wdata;
        lobyte <= 8'h00;
        hibyte <= 8'h00;
      end
      if (state == HI && !write) begin
        lobyte <= mem_rdata;
      end
      if (state == FIN) begin
        hibyte <= mem_rdata;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 16'h0000;
    mem_addr   = 16'h0000;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_wdata  = 8'h00;
    case (state)
      IDLE: req_ready = 1'b1;
      LO: begin
        mem_addr  = addr;
        mem_wdata = wdata[7:0];
        mem_we    = write;
        mem_re    = !write;
      end
      HI: begin
        mem_addr  = addr + 16'd1;
        mem_wdata = wdata[15:8];
        mem_we    = write;
        mem_re    = !write;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write ? 16'h0000 : {hibyte, lobyte};
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a table of directed transactions against
// a byte memory model, plus hand-written back-to-back and reset sequences.
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        experr;
    logic [15:0] exprdata;
  } vec_t;

  vec_t vecs[10];

  lsu_ctrl #(.MEM_BYTES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with one-cycle read latency, cleared by reset.
  logic [7:0] mem [0:31];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[4:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic runTxn(input vec_t v);
    int lat;
    logic [15:0] eaddr;
    logic [7:0]  ebyte;
    lat = v.experr ? 1 : (v.wr ? 3 : 4);
    @(negedge clk);
    applyStimulus(v.wr, v.addr, v.wdata);
    checkOutput("ready_before", {15'd0, req_ready}, 16'd1);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      checkOutput("ready_busy", {15'd0, req_ready}, 16'd0);
      if (!v.experr && c <= 2) begin
        eaddr = (c == 1) ? v.addr : v.addr + 16'd1;
        ebyte = (c == 1) ? v.wdata[7:0] : v.wdata[15:8];
        checkOutput("mem_addr", mem_addr, eaddr);
        checkOutput("mem_we", {15'd0, mem_we}, {15'd0, v.wr});
        checkOutput("mem_re", {15'd0, mem_re}, {15'd0, !v.wr});
        checkOutput("mem_wdata", {8'd0, mem_wdata}, {8'd0, ebyte});
      end else begin
        checkOutput("no_strobe", {14'd0, mem_we, mem_re}, 16'd0);
        checkOutput("mem_addr_zero", mem_addr, 16'd0);
      end
      checkOutput("resp_valid", {15'd0, resp_valid}, {15'd0, (c == lat)});
      if (c == lat) begin
        checkOutput("resp_err", {15'd0, resp_err}, {15'd0, v.experr});
        checkOutput("resp_rdata", resp_rdata, v.exprdata);
      end
    end
    @(negedge clk);
    checkOutput("resp_pulse", {15'd0, resp_valid}, 16'd0);
    checkOutput("ready_after", {15'd0, req_ready}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0004, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0004, 16'h1111, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h001F, 16'h0000, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 16'h001E, 16'h1234, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 16'h001E, 16'h0000, 1'b0, 16'h1234};
    vecs[6] = '{1'b1, 16'h0005, 16'hA55A, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'h5AEF};
    vecs[8] = '{1'b1, 16'h0020, 16'hDEAD, 1'b1, 16'h0000};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    #1;
    checkOutput("rst_ready", {15'd0, req_ready}, 16'd1);
    checkOutput("rst_resp", {14'd0, resp_valid, resp_err}, 16'd0);
    checkOutput("rst_rdata", resp_rdata, 16'd0);
    checkOutput("rst_mem", {6'd0, mem_we, mem_re, mem_wdata}, 16'd0);
    checkOutput("rst_addr", mem_addr, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) runTxn(vecs[i]);

    // Back-to-back: req_valid held high, store then load.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0008, 16'hCAFE);
    checkOutput("b2b_ready0", {15'd0, req_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0008, 16'h0000);
    checkOutput("b2b_lo_ready", {15'd0, req_ready}, 16'd0);
    checkOutput("b2b_lo_addr", mem_addr, 16'h0008);
    checkOutput("b2b_lo_we", {15'd0, mem_we}, 16'd1);
    @(negedge clk);
    checkOutput("b2b_hi_ready", {15'd0, req_ready}, 16'd0);
    checkOutput("b2b_hi_addr", mem_addr, 16'h0009);
    @(negedge clk);
    checkOutput("b2b_resp_ready", {15'd0, req_ready}, 16'd0);
    checkOutput("b2b_resp_valid", {15'd0, resp_valid}, 16'd1);
    @(negedge clk);
    checkOutput("b2b_idle_ready", {15'd0, req_ready}, 16'd1);
    checkOutput("b2b_idle_strobe", {14'd0, mem_we, mem_re}, 16'd0);
    checkOutput("b2b_idle_resp", {15'd0, resp_valid}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("b2b_ld_lo_re", {15'd0, mem_re}, 16'd1);
    checkOutput("b2b_ld_lo_addr", mem_addr, 16'h0008);
    @(negedge clk);
    checkOutput("b2b_ld_hi_addr", mem_addr, 16'h0009);
    @(negedge clk);
    checkOutput("b2b_ld_fin", {15'd0, resp_valid}, 16'd0);
    @(negedge clk);
    checkOutput("b2b_ld_valid", {15'd0, resp_valid}, 16'd1);
    checkOutput("b2b_ld_rdata", resp_rdata, 16'hCAFE);

    // Reset asynchronously during the HI cycle of a store.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0010, 16'h7777);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_lo_we", {15'd0, mem_we}, 16'd1);
    @(negedge clk);
    checkOutput("rst_hi_addr", mem_addr, 16'h0011);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_mid_we", {15'd0, mem_we}, 16'd0);
    checkOutput("rst_mid_ready", {15'd0, req_ready}, 16'd1);
    checkOutput("rst_mid_addr", mem_addr, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_no_resp", {15'd0, resp_valid}, 16'd0);
      checkOutput("rst_idle_ready", {15'd0, req_ready}, 16'd1);
    end
    runTxn('{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
